// File: rtl/tile_serializer.sv
// Tile serializer: picks the lowest-indexed pending warp tile, buffers its pixels and
// streams them over valid/ready. Define TILE_SERIALIZER_SERPENTINE_EN for serpentine scan order.
module tile_serializer #(
  parameter int WARP_WIDTH     = 8,
  parameter int WARP_HEIGHT    = 8,
  parameter int TILE_WIDTH     = 8,
  parameter int TILE_HEIGHT    = 8,
  parameter int NUM_TILES      = WARP_WIDTH * WARP_HEIGHT,
  parameter int TILE_IDX_WIDTH = $clog2(NUM_TILES),
  parameter int COLORS         = 3,
  parameter int COLOR_DEPTH    = 8,
  parameter int DATA_WIDTH     = COLORS * COLOR_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_TILES-1:0]          tile_valid,
  input  logic [DATA_WIDTH-1:0]         tile_in [TILE_WIDTH][TILE_HEIGHT],
  output logic [TILE_IDX_WIDTH-1:0]     tile_sel,
  output logic                          tile_ack,
  output logic [DATA_WIDTH-1:0]         pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          pix_last,
  output logic [$clog2(TILE_WIDTH)-1:0] pix_x,
  output logic [$clog2(TILE_HEIGHT)-1:0] pix_y,
  output logic                          busy
);

  localparam int PIX = TILE_WIDTH * TILE_HEIGHT;
  localparam int CW  = $clog2(PIX);
  localparam int XW  = $clog2(TILE_WIDTH);
  localparam int YW  = $clog2(TILE_HEIGHT);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, ACK} state_t;

  state_t                  state, state_next;
  logic [NUM_TILES-1:0]    served;
  logic [NUM_TILES-1:0]    pending;
  logic [TILE_IDX_WIDTH-1:0] first_idx;
  logic [CW-1:0]           count;
  logic                    last_pix;
  logic [XW-1:0]           col;
  logic [XW-1:0]           x_scan;
  logic [YW-1:0]           row;
  logic                    streaming;
  logic [DATA_WIDTH-1:0]   buffer [TILE_WIDTH][TILE_HEIGHT];

  assign pending  = tile_valid & ~served;
  assign last_pix = (count == CW'(PIX - 1));

  // Lowest set index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (pending[i]) first_idx = TILE_IDX_WIDTH'(i);
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && (|pending)) state_next = LOAD;
      LOAD:    state_next = STREAM;
      STREAM:  if (pix_ready && last_pix) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tile_sel <= '0;
      served   <= '0;
      count    <= '0;
    end else begin
      state  <= state_next;
      served <= served & tile_valid;
      case (state)
        IDLE:    if (state_next == LOAD) tile_sel <= first_idx;
        LOAD: begin
          served[tile_sel] <= 1'b1;
          count            <= '0;
        end
        // The counter stops on the last pixel instead of wrapping.
        STREAM:  if (pix_ready && !last_pix) count <= count + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the pixel buffer is storage, not control; it is not reset because outputs are gated outside STREAM.
  always_ff @(posedge clk) begin
    if (state == LOAD) buffer <= tile_in;
  end

  assign streaming = (state == STREAM);
  assign col       = XW'(count % CW'(TILE_WIDTH));
  assign row       = YW'(count / CW'(TILE_WIDTH));

`ifdef TILE_SERIALIZER_SERPENTINE_EN
  assign x_scan = row[0] ? (XW'(TILE_WIDTH - 1) - col) : col;
`else
  assign x_scan = col;
`endif

  assign pix_valid = streaming;
  assign pix_last  = streaming && last_pix;
  assign pix_x     = streaming ? x_scan : '0;
  assign pix_y     = streaming ? row : '0;
  assign pix_data  = streaming ? buffer[x_scan][row] : '0;
  assign tile_ack  = (state == ACK);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_tile_serializer.sv
// Directed self-checking bench for tile_serializer: reset, single tile, priority,
// backpressure, enable gating and mid-tile reset.
module tb_tile_serializer;

  localparam int DW = 24;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [63:0]   tile_valid;
  logic [DW-1:0] tile_in [8][8];
  logic [5:0]    tile_sel;
  logic          tile_ack;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_last;
  logic [2:0]    pix_x;
  logic [2:0]    pix_y;
  logic          busy;

  int checks = 0;
  int errors = 0;

  tile_serializer dut (
    .clk(clk), .rst(rst), .enable(enable), .tile_valid(tile_valid), .tile_in(tile_in),
    .tile_sel(tile_sel), .tile_ack(tile_ack), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_x(input int k);
    int c;
    c = k % 8;
`ifdef TILE_SERIALIZER_SERPENTINE_EN
    if ((k / 8) % 2 == 1) c = 7 - c;
`endif
    return 3'(c);
  endfunction

  function automatic logic [2:0] exp_y(input int k);
    return 3'(k / 8);
  endfunction

  function automatic logic [DW-1:0] exp_pix(input int k);
    return {5'd0, exp_x(k), 5'd0, exp_y(k), 8'hA5};
  endfunction

  // Collects pixels start_k..stop_k-1 of tile sel; stop_k==64 also checks the ack pulse.
  task automatic receive_tile(input int sel, input int max_wait, input bit bp,
                              input int start_k, input int stop_k);
    int k;
    int w;
    int cyc;
    logic ready;
    logic [15:0] ready_pat;
    ready_pat = 16'b1011_0010_1110_0101;
    k = start_k;
    w = 0;
    cyc = 0;
    while (!pix_valid && w < max_wait) begin
      step();
      w++;
    end
    checks++;
    if (pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL start_tile%0d: pix_valid=%b required 1 within %0d cycles", sel, pix_valid, max_wait);
      return;
    end
    checks++;
    if (tile_sel !== 6'(sel)) begin
      errors++;
      $display("FAIL tile_sel: got %0d required %0d", tile_sel, sel);
    end
    while (k < stop_k) begin
      if (cyc > 400) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout tile%0d: stuck at pixel %0d required %0d", sel, k, stop_k);
        return;
      end
      checks++;
      if (pix_valid !== 1'b1 || pix_x !== exp_x(k) || pix_y !== exp_y(k) ||
          pix_data !== exp_pix(k) || pix_last !== (k == 63)) begin
        errors++;
        $display("FAIL pixel%0d tile%0d: v=%b x=%0d y=%0d d=%h last=%b required v=1 x=%0d y=%0d d=%h last=%b",
                 k, sel, pix_valid, pix_x, pix_y, pix_data, pix_last,
                 exp_x(k), exp_y(k), exp_pix(k), (k == 63));
      end
      if (bp) ready = (cyc >= 5 && cyc < 15) ? 1'b0 : ready_pat[cyc % 16];
      else    ready = 1'b1;
      pix_ready = ready;
      step();
      cyc++;
      if (ready) k++;
    end
    if (stop_k == 64) begin
      checks++;
      if (tile_ack !== 1'b1 || pix_valid !== 1'b0 || tile_sel !== 6'(sel)) begin
        errors++;
        $display("FAIL ack_tile%0d: ack=%b valid=%b sel=%0d required ack=1 valid=0 sel=%0d",
                 sel, tile_ack, pix_valid, tile_sel, sel);
      end
      step();
      checks++;
      if (tile_ack !== 1'b0) begin
        errors++;
        $display("FAIL ack_pulse_tile%0d: ack=%b required 0 after one cycle", sel, tile_ack);
      end
    end
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (tile_sel !== 6'd0 || tile_ack !== 1'b0 || pix_valid !== 1'b0 || pix_last !== 1'b0 ||
        pix_x !== 3'd0 || pix_y !== 3'd0 || pix_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: sel=%0d ack=%b v=%b last=%b x=%0d y=%0d d=%h busy=%b required all 0",
               tile_sel, tile_ack, pix_valid, pix_last, pix_x, pix_y, pix_data, busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    tile_valid = 64'd1 << 5;
    step();
    checks++;
    if (busy !== 1'b1 || pix_valid !== 1'b0 || tile_sel !== 6'd5) begin
      errors++;
      $display("FAIL load_cycle: busy=%b valid=%b sel=%0d required busy=1 valid=0 sel=5",
               busy, pix_valid, tile_sel);
    end
    step();
    receive_tile(5, 0, 1'b0, 0, 64);
    tile_valid = '0;
    step();
  endtask

  task automatic test_priority();
    tile_valid = (64'd1 << 3) | (64'd1 << 40);
    receive_tile(3, 3, 1'b0, 0, 64);
    receive_tile(40, 3, 1'b0, 0, 64);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL no_reserve cycle%0d: busy=%b required 0", i, busy);
      end
    end
    tile_valid[3] = 1'b0;
    step();
    tile_valid[3] = 1'b1;
    receive_tile(3, 3, 1'b0, 0, 64);
    tile_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    tile_valid = 64'd1 << 12;
    receive_tile(12, 3, 1'b1, 0, 64);
    tile_valid = '0;
    step();
  endtask

  task automatic test_enable();
    enable = 1'b0;
    tile_valid = 64'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL enable_gate cycle%0d: busy=%b valid=%b required 0 0", i, busy, pix_valid);
      end
    end
    enable = 1'b1;
    receive_tile(0, 3, 1'b0, 0, 10);
    enable = 1'b0;
    tile_valid[1] = 1'b1;
    receive_tile(0, 0, 1'b0, 10, 64);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold cycle%0d: busy=%b required 0", i, busy);
      end
    end
    enable = 1'b1;
    receive_tile(1, 3, 1'b0, 0, 64);
    tile_valid = '0;
    step();
  endtask

  task automatic test_reset_mid_tile();
    tile_valid = 64'd1 << 9;
    receive_tile(9, 3, 1'b0, 0, 20);
    rst = 1'b1;
    step();
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || tile_ack !== 1'b0 || tile_sel !== 6'd0 ||
        pix_x !== 3'd0 || pix_y !== 3'd0 || pix_data !== '0 || pix_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: v=%b busy=%b ack=%b sel=%0d x=%0d y=%0d d=%h last=%b required all 0",
               pix_valid, busy, tile_ack, tile_sel, pix_x, pix_y, pix_data, pix_last);
    end
    rst = 1'b0;
    receive_tile(9, 3, 1'b0, 0, 64);
    tile_valid = '0;
    step();
  endtask

  initial begin
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        tile_in[x][y] = {8'(x), 8'(y), 8'hA5};
    rst        = 1'b1;
    enable     = 1'b1;
    tile_valid = '0;
    pix_ready  = 1'b1;
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_enable();
    test_reset_mid_tile();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_serializer.md
# tile_serializer

Read-side companion to the warp tile store. It scans the warp's per-tile valid flags, selects the lowest-indexed pending tile, and captures that tile's 8x8 pixel array in one cycle. It then streams the tile out one pixel per valid/ready handshake toward the scan-out/framebuffer path, and pulses an acknowledge so the warp can retire the tile.

## Interface
Parameters:
- WARP_WIDTH, 8, tiles per warp row
- WARP_HEIGHT, 8, tiles per warp column
- TILE_WIDTH, 8, pixels per tile row (x)
- TILE_HEIGHT, 8, pixels per tile column (y)
- NUM_TILES, WARP_WIDTH*WARP_HEIGHT, tiles per warp
- TILE_IDX_WIDTH, $clog2(NUM_TILES), tile index width
- COLORS, 3, channels per pixel
- COLOR_DEPTH, 8, bits per channel
- DATA_WIDTH, COLORS*COLOR_DEPTH, pixel width

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  permits starting a new tile
- tile_valid  in  NUM_TILES  per-tile "data ready" flags from warp
- tile_in  in  DATA_WIDTH x [TILE_WIDTH][TILE_HEIGHT]  pixel array of tile tile_sel, indexed [x][y]; parent muxes combinationally from tile_sel
- tile_sel  out  TILE_IDX_WIDTH  index of tile being loaded/streamed
- tile_ack  out  1  one-cycle pulse: tile tile_sel fully streamed
- pix_data  out  DATA_WIDTH  current pixel
- pix_valid  out  1  pixel valid
- pix_ready  in  1  downstream accepts pixel
- pix_last  out  1  current pixel is last of tile
- pix_x  out  $clog2(TILE_WIDTH)  pixel x within tile
- pix_y  out  $clog2(TILE_HEIGHT)  pixel y within tile
- busy  out  1  FSM not in IDLE

## Operation
- Pending mask = tile_valid & ~served. served[i] is set when tile i is loaded and is cleared in any cycle where tile_valid[i]==0. A tile is therefore not re-served until the warp drops and re-raises its flag.
- FSM states: IDLE, LOAD, STREAM, ACK.
- IDLE: if enable and pending != 0, register tile_sel <= lowest set index of pending, go to LOAD. Otherwise stay.
- LOAD: tile_sel stable; capture tile_in into the internal buffer; set served[tile_sel]; clear the pixel counter; go to STREAM.
- STREAM: pix_valid=1. Pixel k maps to y=k/TILE_WIDTH, x=k%TILE_WIDTH (row-major). On pix_valid && pix_ready, k increments. pix_last=1 when k==TILE_WIDTH*TILE_HEIGHT-1. A handshake on the last pixel goes to ACK.
- ACK: tile_ack=1 for exactly one cycle; tile_sel holds; go to IDLE.
- enable is sampled only in IDLE. A tile already in LOAD, STREAM or ACK completes regardless of enable.
- tile_valid changes after LOAD do not affect the buffered tile.
- Counter width is $clog2(TILE_WIDTH*TILE_HEIGHT). There is no wrap-around; the counter is cleared in LOAD.

## Timing
- Reset values: tile_sel=0, tile_ack=0, pix_valid=0, pix_last=0, pix_x=0, pix_y=0, pix_data=0, busy=0, served=all 0, state=IDLE.
- Latency: pending seen in IDLE at cycle N gives LOAD at N+1 and pix_valid=1 with pixel (0,0) at N+2.
- Best-case throughput: 64 pixels in 64 cycles. Total per tile with pix_ready held high is 1 IDLE + 1 LOAD + 64 STREAM + 1 ACK = 67 cycles. The next tile can start in the cycle after ACK (IDLE).
- Handshake: while pix_valid && !pix_ready, pix_data, pix_x, pix_y and pix_last hold stable. pix_valid never drops mid-tile except on rst.
- pix_ready=0 for any number of cycles stalls STREAM indefinitely.
- Simultaneous events: if several tiles are pending, the lowest index wins. A tile whose flag rises during STREAM is picked in the next IDLE.
- Reset mid-operation: the next cycle has all outputs at reset values. No tile_ack is issued for the aborted tile, and served is cleared.

## Configuration
- TILE_SERIALIZER_SERPENTINE_EN undefined: row-major scan. Every row runs x = 0..TILE_WIDTH-1.
- TILE_SERIALIZER_SERPENTINE_EN defined: serpentine scan.
  - Even rows run x ascending; odd rows run x descending.
  - pix_x reports the actual x. pix_last is asserted on the final pixel: (0, TILE_HEIGHT-1) when TILE_HEIGHT is even.
- Ports, latency and handshake are identical in both builds.

## Test plan
- Single tile: rst, then tile_valid[5]=1, tile_in[x][y]={x,y,8'hA5}, pix_ready=1.
  - tile_sel=5; pix_valid rises 2 cycles after the first IDLE.
  - 64 pixels arrive in row-major order with matching data; pix_last on (7,7); tile_ack pulses once, one cycle after the last handshake.
- Priority: tile_valid[3] and tile_valid[40] set together.
  - Tile 3 streams first, then tile 40.
  - No re-serve of tile 3 while its flag stays high; it is served again after the flag goes 0 then 1.
- Backpressure: pix_ready toggles in a random pattern, including a 10-cycle low.
  - Outputs hold stable while stalled.
  - Exactly 64 handshakes, no duplicates or skips.
- Enable gating:
  - enable=0 with tile 0 pending: stays IDLE, busy=0.
  - Dropping enable mid-STREAM: the tile finishes and tile_ack fires; no new tile starts until enable=1.
- Reset mid-tile: rst at pixel 20.
  - Next cycle: pix_valid=0, busy=0, no tile_ack.
  - After release, the same tile (still valid) is re-served from pixel (0,0).
- Serpentine build (macro defined): row 1 is emitted x=7..0 and the final pixel is (0,7) with pix_last=1.
